// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared widths and state type for the serial 32:5 encoder
package encoder_pkg;
    localparam int ENC_WIDTH    = 32;
    localparam int ENC_SEL_BITS = 5;

    typedef logic [ENC_WIDTH-1:0]    enc_mask_t;
    typedef logic [ENC_SEL_BITS-1:0] enc_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } enc_state_t;
endpackage

// File: rtl/encoder32_5_serial_if.sv
// rtl/encoder32_5_serial_if.sv - mask-in / index-out handshake bundle
interface encoder32_5_serial_if;
    import encoder_pkg::*;

    logic      in_valid;
    logic      in_ready;
    enc_mask_t in_mask;
    logic      out_valid;
    logic      out_ready;
    enc_idx_t  out_idx;
    logic      out_last;
    logic      busy;

    modport master (
        output in_valid, in_mask, out_ready,
        input  in_ready, out_valid, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_mask, out_ready,
        output in_ready, out_valid, out_idx, out_last, busy
    );
endinterface

// File: rtl/priority_encoder32_5.sv
// rtl/priority_encoder32_5.sv - combinational find-first-set; ENCODER_MSB_FIRST_EN scans from the top
module priority_encoder32_5
    import encoder_pkg::*;
(
    input  enc_mask_t mask,
    output enc_idx_t  idx,
    output logic      found,
    output logic      onehot
);
    always_comb begin
        idx = '0;
`ifdef ENCODER_MSB_FIRST_EN
        for (int i = 0; i < ENC_WIDTH; i++) begin
            if (mask[i]) idx = ENC_SEL_BITS'(i);
        end
`else
        for (int i = ENC_WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) idx = ENC_SEL_BITS'(i);
        end
`endif
    end

    // Clearing the lowest set bit leaves zero only for a single-bit mask.
    assign found  = |mask;
    assign onehot = found && ((mask & (mask - enc_mask_t'(1))) == '0);
endmodule

// File: rtl/encoder32_5_serial.sv
// rtl/encoder32_5_serial.sv - serial 32:5 encoder, one set-bit index per handshake; order set by ENCODER_MSB_FIRST_EN
module encoder32_5_serial
    import encoder_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    encoder32_5_serial_if.slave  bus
);
    enc_state_t state;
    enc_mask_t  pending;
    enc_idx_t   pe_idx;
    logic       pe_found;
    logic       pe_onehot;
    logic       out_fire;
    logic       in_fire;

    priority_encoder32_5 u_pe (
        .mask   (pending),
        .idx    (pe_idx),
        .found  (pe_found),
        .onehot (pe_onehot)
    );

    assign bus.out_valid = (state == DRAIN) && pe_found;
    assign bus.out_idx   = bus.out_valid ? pe_idx : '0;
    assign bus.out_last  = bus.out_valid && pe_onehot;
    assign bus.busy      = (state == DRAIN);

    assign out_fire     = bus.out_valid && bus.out_ready;
    assign bus.in_ready = (state == IDLE) || (out_fire && bus.out_last);
    assign in_fire      = bus.in_valid && bus.in_ready;

    // A new mask accepted on the final handshake overrides the drain exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            if (out_fire) begin
                pending <= pending & ~(enc_mask_t'(1) << pe_idx);
                if (bus.out_last) state <= IDLE;
            end
            if (in_fire) begin
                if (bus.in_mask != '0) begin
                    pending <= bus.in_mask;
                    state   <= DRAIN;
                end else begin
                    state   <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_encoder32_5_serial.sv
// tb/tb_encoder32_5_serial.sv - directed self-checking bench for encoder32_5_serial
module tb_encoder32_5_serial;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_q[$];

    encoder32_5_serial_if bus();

    encoder32_5_serial dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] mask);
        bus.in_valid = 1'b1;
        bus.in_mask  = mask;
        check("send in_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.in_mask  = '0;
    endtask

    task automatic drain_check(input string tag);
        int n;
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            check({tag, " valid"}, bus.out_valid, 1);
            check($sformatf("%s idx[%0d]", tag, k), bus.out_idx, exp_q[k]);
            check($sformatf("%s last[%0d]", tag, k), bus.out_last, (k == n - 1));
            step();
        end
        check({tag, " done"}, bus.out_valid, 0);
        check({tag, " idle"}, bus.busy, 0);
        exp_q.delete();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_mask   = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        repeat (2) step();
        check("rst in_ready", bus.in_ready, 1);
        check("rst out_valid", bus.out_valid, 0);
        check("rst out_idx", bus.out_idx, 0);
        check("rst out_last", bus.out_last, 0);
        check("rst busy", bus.busy, 0);
        reset = 1'b0;
        step();

        // three-bit mask, free-running consumer
        send(32'h8000_0005);
`ifdef ENCODER_MSB_FIRST_EN
        exp_q = '{31, 2, 0};
`else
        exp_q = '{0, 2, 31};
`endif
        drain_check("m80000005");

        // zero mask is swallowed
        send(32'h0);
        for (int k = 0; k < 3; k++) begin
            check("zero out_valid", bus.out_valid, 0);
            check("zero in_ready", bus.in_ready, 1);
            step();
        end

        // stall on a single-bit mask
        bus.out_ready = 1'b0;
        send(32'h0000_0010);
        for (int k = 0; k < 3; k++) begin
            check("stall valid", bus.out_valid, 1);
            check("stall idx", bus.out_idx, 4);
            check("stall last", bus.out_last, 1);
            check("stall in_ready", bus.in_ready, 0);
            step();
        end
        bus.out_ready = 1'b1;
        exp_q = '{4};
        drain_check("stall release");

        // back-to-back masks, no bubble
        send(32'h0000_0003);
`ifdef ENCODER_MSB_FIRST_EN
        check("b2b idx0", bus.out_idx, 1);
`else
        check("b2b idx0", bus.out_idx, 0);
`endif
        check("b2b last0", bus.out_last, 0);
        check("b2b ready0", bus.in_ready, 0);
        step();
`ifdef ENCODER_MSB_FIRST_EN
        check("b2b idx1", bus.out_idx, 0);
`else
        check("b2b idx1", bus.out_idx, 1);
`endif
        check("b2b last1", bus.out_last, 1);
        check("b2b ready1", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_mask  = 32'h0000_0100;
        step();
        bus.in_valid = 1'b0;
        bus.in_mask  = '0;
        exp_q = '{8};
        drain_check("b2b second");

        // reset mid-drain
        send(32'h0000_00F0);
        check("rstd idx0", bus.out_idx, 4);
        step();
        check("rstd idx1", bus.out_idx, 5);
        reset = 1'b1;
        #1;
        check("rstd async valid", bus.out_valid, 0);
        step();
        reset = 1'b0;
        check("rstd in_ready", bus.in_ready, 1);
        check("rstd out_idx", bus.out_idx, 0);
        check("rstd busy", bus.busy, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rstd quiet", bus.out_valid, 0);
        end

        // every single-bit mask
        for (int i = 0; i < 32; i++) begin
            send(32'h1 << i);
            exp_q = '{i};
            drain_check($sformatf("bit%0d", i));
        end

        // full mask
        send(32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) begin
`ifdef ENCODER_MSB_FIRST_EN
            exp_q.push_back(31 - i);
`else
            exp_q.push_back(i);
`endif
        end
        drain_check("full");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
